// File: rtl/dds_pkg.sv
// Shared definitions for the DDS output path and its frequency meter.
package dds_pkg;

    localparam logic [15:0] MIDSCALE = 16'h8000;
    localparam int          PHASE_W  = 32;

    typedef enum logic [1:0] {
        SYNC,
        MEASURE,
        DIVIDE
    } meter_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider producing one quotient bit per clock.
// The dividend register shifts its MSB into the partial remainder while
// quotient bits shift in at the LSB, so it ends up holding the quotient.
module seq_divider #(
    parameter int DVD_W = 35,
    parameter int DVS_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder
);

    localparam int CW = $clog2(DVD_W + 1);

    logic [DVD_W-1:0] dvd_sh;
    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] dvs_q;
    logic [CW-1:0]    bit_cnt;

    logic [DVS_W:0]   partial;
    logic [DVS_W:0]   diff;
    logic             fits;
    logic [DVS_W-1:0] rem_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // Because rem < divisor, both branches fit back into DVS_W bits.
    always_comb begin
        partial  = {rem, dvd_sh[DVD_W-1]};
        diff     = partial - {1'b0, dvs_q};
        fits     = (partial >= {1'b0, dvs_q});
        rem_next = fits ? diff[DVS_W-1:0] : partial[DVS_W-1:0];
    end

    // Load on start, then iterate DVD_W times; done pulses after the last step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd_sh  <= '0;
            rem     <= '0;
            dvs_q   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values; blocking would chain the steps in one clock.
            done <= 1'b0;
            if (start && !busy) begin
                dvd_sh  <= dividend;
                rem     <= '0;
                dvs_q   <= divisor;
                bit_cnt <= CW'(DVD_W);
                busy    <= 1'b1;
            end else if (busy) begin
                dvd_sh  <= {dvd_sh[DVD_W-2:0], fits};
                rem     <= rem_next;
                bit_cnt <= bit_cnt - 1'b1;
                if (bit_cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = dvd_sh;
    assign remainder = rem;

endmodule

// File: rtl/wave_freq_meter.sv
// Frequency estimator: finds rising midscale crossings with hysteresis,
// sums 2^AVG_LOG2 periods and converts the window length back into the
// phase-step word that a DDS would need to produce that frequency.
module wave_freq_meter
    import dds_pkg::*;
#(
    parameter int          AVG_LOG2 = 2,
    parameter int          CNT_W    = 24,
    parameter logic [15:0] HYST     = 16'd256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [15:0]               sample,
    output logic [31:0]               Step_est,
    output logic                      step_valid,
    output logic [CNT_W+AVG_LOG2-1:0] window_cycles,
    output logic                      no_signal
);

    localparam int WIN_W = CNT_W + AVG_LOG2;
    localparam int DVD_W = 33 + AVG_LOG2;
    localparam int PC_W  = AVG_LOG2 + 1;

    localparam logic [15:0]       LOW_TH   = MIDSCALE - HYST;
    localparam logic [15:0]       HIGH_TH  = MIDSCALE + HYST;
    localparam logic [PC_W-1:0]   LAST_PER = PC_W'(2**AVG_LOG2 - 1);
    localparam logic [WIN_W-1:0]  WIN_MIN  = WIN_W'(2**AVG_LOG2);
    localparam logic [DVD_W-1:0]  DIVIDEND = {1'b1, {(DVD_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  T_MAX    = '1;
    localparam logic [CNT_W-1:0]  T_LAST   = {{(CNT_W-1){1'b1}}, 1'b0};

    meter_state_t      state;
    logic              low_armed;
    logic              rise;
    logic [WIN_W-1:0]  acc;
    logic [WIN_W-1:0]  acc_inc;
    logic [PC_W-1:0]   pcnt;
    logic [CNT_W-1:0]  tcnt;
    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [DVD_W-1:0]  div_q;
    logic [WIN_W-1:0]  div_rem_unused;
    logic              step_sat;

    assign rise     = low_armed && (sample >= HIGH_TH);
    assign acc_inc  = (&acc) ? acc : acc + 1'b1;
    assign step_sat = (window_cycles <= WIN_MIN) || (|div_q[DVD_W-1:PHASE_W]);

    // Hysteresis crossing detector: arm below the band, fire above it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_armed <= 1'b0;
        end else if (rise) begin
            low_armed <= 1'b0;
        end else if (sample < LOW_TH) begin
            low_armed <= 1'b1;
        end
    end

    // Measurement FSM with window accumulation, result latch and timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= SYNC;
            acc           <= '0;
            pcnt          <= '0;
            tcnt          <= '0;
            div_start     <= 1'b0;
            Step_est      <= '0;
            step_valid    <= 1'b0;
            window_cycles <= '0;
            no_signal     <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            div_start  <= 1'b0;

            case (state)
                SYNC: begin
                    if (rise) begin
                        acc   <= '0;
                        pcnt  <= '0;
                        tcnt  <= '0;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    acc <= acc_inc;
                    if (rise) begin
                        tcnt <= '0;
                        if (pcnt == LAST_PER && !div_busy) begin
                            window_cycles <= acc_inc;
                            div_start     <= 1'b1;
                            state         <= DIVIDE;
                        end else begin
                            pcnt <= pcnt + 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        Step_est   <= step_sat ? 32'hFFFF_FFFF : div_q[31:0];
                        step_valid <= 1'b1;
                        no_signal  <= 1'b0;
                        state      <= SYNC;
                    end
                end
                default: state <= SYNC;
            endcase

            // Timeout runs outside DIVIDE and overrides the case above.
            if (state != DIVIDE && !rise && tcnt != T_MAX) begin
                tcnt <= tcnt + 1'b1;
                if (tcnt == T_LAST) begin
                    no_signal  <= 1'b1;
                    Step_est   <= '0;
                    step_valid <= 1'b1;
                    state      <= SYNC;
                end
            end
        end
    end

    seq_divider #(
        .DVD_W(DVD_W),
        .DVS_W(WIN_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (window_cycles),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q),
        .remainder(div_rem_unused)
    );

endmodule

// File: tb/tb_wave_freq_meter.sv
// Self-checking bench for wave_freq_meter: DDS, sawtooth and square stimulus
// against a period-arithmetic reference model.
module tb_wave_freq_meter;

    localparam int          AVG_LOG2 = 2;
    localparam int          CNT_W    = 12;
    localparam int          WIN_W    = CNT_W + AVG_LOG2;
    localparam int          N_PER    = 2**AVG_LOG2;
    localparam logic [15:0] HYST     = 16'd256;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      sample;
    logic [31:0]      Step_est;
    logic             step_valid;
    logic [WIN_W-1:0] window_cycles;
    logic             no_signal;

    wave_freq_meter #(
        .AVG_LOG2(AVG_LOG2),
        .CNT_W   (CNT_W),
        .HYST    (HYST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample),
        .Step_est     (Step_est),
        .step_valid   (step_valid),
        .window_cycles(window_cycles),
        .no_signal    (no_signal)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus generator ----------------
    typedef enum {G_DDS, G_SAW, G_SQUARE} gen_t;
    gen_t        gen_mode = G_DDS;
    logic [31:0] phase    = '0;
    logic [31:0] dds_step = '0;
    int          saw_p    = 64;
    int          saw_t    = 0;
    int          sq_t     = 0;
    bit          glitch_en = 1'b0;

    task automatic gen_sample(output logic [15:0] s);
        int g;
        case (gen_mode)
            G_DDS: begin
                s     = phase[31:16];
                phase = phase + dds_step;
            end
            G_SAW: begin
                s     = 16'((saw_t * 65536) / saw_p);
                saw_t = (saw_t + 1) % saw_p;
            end
            default: begin
                sq_t++;
                s = ((sq_t / 4) % 2 == 1) ? 16'h8064 : 16'h7F9C;
            end
        endcase
        // Glitches only on near-midscale samples, kept strictly inside the band.
        if (glitch_en && s >= 16'h7FC9 && s <= 16'h8037) begin
            g = int'(s) + int'($urandom_range(0, 400)) - 200;
            s = 16'(g);
        end
    endtask

    // ---------------- output monitor ----------------
    int               n_valid     = 0;
    int               wide_pulses = 0;
    bit               prev_valid  = 1'b0;
    logic [31:0]      last_step;
    logic [WIN_W-1:0] last_win;
    logic             last_nosig;

    task automatic tick();
        logic [15:0] s;
        @(negedge clk);
        if (step_valid === 1'b1) begin
            n_valid++;
            if (prev_valid) wide_pulses++;
            last_step  = Step_est;
            last_win   = window_cycles;
            last_nosig = no_signal;
        end
        prev_valid = (step_valid === 1'b1);
        gen_sample(s);
        sample = s;
    endtask

    task automatic wait_valid(input int budget, output bit got);
        int start_n = n_valid;
        for (int i = 0; i < budget && n_valid == start_n; i++) tick();
        got = (n_valid != start_n);
    endtask

    // Reference: a window of N periods of P clocks, step = floor(2^34 / window).
    function automatic logic [31:0] exp_step(input int win);
        logic [63:0] q;
        if (win <= N_PER) return 32'hFFFF_FFFF;
        q = (64'd1 << (32 + AVG_LOG2)) / 64'(win);
        return (q > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
    endfunction

    task automatic measure(input string tag, input int period);
        bit got;
        wait_valid(20000, got);
        check({tag, " arrived"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, " window"}, 64'(last_win), 64'(N_PER * period));
            check({tag, " step"}, 64'(last_step), 64'(exp_step(N_PER * period)));
            check({tag, " no_signal"}, 64'(last_nosig), 64'd0);
        end
    endtask

    task automatic discard_one(input string tag);
        bit got;
        wait_valid(20000, got);
        check({tag, " resync"}, 64'(got), 64'd1);
    endtask

    task automatic use_dds(input logic [31:0] st);
        gen_mode = G_DDS;
        dds_step = st;
        phase    = '0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit          got;
        int          v0;
        logic [63:0] sum;
        logic [31:0] avg;

        reset  = 1'b1;
        sample = 16'h8000;
        repeat (3) @(negedge clk);
        check("reset Step_est", 64'(Step_est), 64'd0);
        check("reset step_valid", 64'(step_valid), 64'd0);
        check("reset window", 64'(window_cycles), 64'd0);
        check("reset no_signal", 64'(no_signal), 64'd0);
        reset = 1'b0;

        // Period 256 from a clean start: both measurements exact.
        use_dds(32'h0100_0000);
        measure("dds256 a", 256);
        measure("dds256 b", 256);

        // Period 32, repeated measurements identical.
        use_dds(32'h0800_0000);
        discard_one("dds32");
        for (int i = 0; i < 3; i++) measure($sformatf("dds32 #%0d", i), 32);

        // Non-integer period ~48: average of 8 estimates within 1 LSB.
        use_dds(32'h0555_5555);
        discard_one("frac");
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            wait_valid(20000, got);
            check($sformatf("frac arrived #%0d", i), 64'(got), 64'd1);
            sum = sum + 64'(last_step);
        end
        avg = 32'(sum / 8);
        check("frac avg", 64'((avg >= 32'h0555_5554 && avg <= 32'h0555_5556) ? 32'h0555_5555 : avg),
              64'h0555_5555);

        // Random integer-period sawtooth, optionally with in-band glitches.
        for (int i = 0; i < 5; i++) begin
            gen_mode  = G_SAW;
            saw_p     = $urandom_range(20, 300);
            saw_t     = 0;
            glitch_en = ($urandom_range(0, 1) == 1);
            discard_one($sformatf("saw%0d", i));
            measure($sformatf("saw%0d P=%0d a", i, saw_p), saw_p);
            measure($sformatf("saw%0d P=%0d b", i, saw_p), saw_p);
        end

        // Period 256 with +-200 noise around midscale: unchanged estimate.
        use_dds(32'h0100_0000);
        glitch_en = 1'b1;
        discard_one("noise");
        measure("noise a", 256);
        measure("noise b", 256);
        glitch_en = 1'b0;

        // Square wave inside the band: only the timeout path.
        gen_mode = G_SQUARE;
        sq_t     = 0;
        wait_valid(5000, got);
        check("timeout arrived", 64'(got), 64'd1);
        check("timeout no_signal", 64'(last_nosig), 64'd1);
        check("timeout Step_est", 64'(last_step), 64'd0);
        v0 = n_valid;
        repeat (6000) tick();
        check("timeout single pulse", 64'(n_valid - v0), 64'd0);
        check("timeout no_signal held", 64'(no_signal), 64'd1);

        // Real signal again: next measurement clears no_signal.
        use_dds(32'h0100_0000);
        measure("recover", 256);

        // Reset during DIVIDE aborts the divider with no pulse.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        use_dds(32'h0100_0000);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            tick();
            got = (window_cycles != '0);
        end
        check("divide entered", 64'(got), 64'd1);
        check("divide window", 64'(window_cycles), 64'(N_PER * 256));
        repeat (10) tick();
        v0 = n_valid;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst Step_est", 64'(Step_est), 64'd0);
        check("midrst step_valid", 64'(step_valid), 64'd0);
        check("midrst window", 64'(window_cycles), 64'd0);
        check("midrst no_signal", 64'(no_signal), 64'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (60) tick();
        check("midrst no pulse", 64'(n_valid - v0), 64'd0);
        measure("after midrst", 256);

        check("pulse width", 64'(wide_pulses), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
